i2s_video_rx: RTL and testbench

- Receiver end of the serial pixel link: recovers 12-bit RGB444 pixels from the gated bit clock, data and word-select lines driven by the pixel transmitter.
- Oversamples the link on the local system clock and aligns words on word-select transitions.
- Delivers pixels expanded to 24-bit RGB over a valid/ready interface and reports frame boundaries, detected when the bit clock goes idle during vertical sync.
- Sits in the control-system FPGA between the link pins and the frame buffer writer.

---
 rtl/i2s_video_pkg.sv | 23 ++
 rtl/sync_edge_det.sv | 35 +++
 rtl/i2s_video_rx.sv | 168 ++++++++++++++++
 tb/tb_i2s_video_rx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_video_pkg.sv
// Shared types for the serial pixel link receiver: pixel word layout,
// receiver states and the RGB444 to RGB888 expansion.
package i2s_video_pkg;

    localparam int DEF_PIX_BITS = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic {
        ALIGN   = 1'b0,
        RECEIVE = 1'b1
    } rx_state_t;

    // Nibble replication maps 0x0 to 0x00 and 0xF to 0xFF exactly.
    function automatic logic [23:0] expand444(input rgb444_t p);
        return {p.r, p.r, p.g, p.g, p.b, p.b};
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for a bundle of asynchronous link lines, with a
// rising-edge pulse on the one line that carries the bit clock.
module sync_edge_det #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         edge_in,
    input  logic [W-1:0] pass_in,
    output logic [W-1:0] pass_out,
    output logic         rise
);

    logic [STAGES-1:0][W:0] chain;
    logic                   edge_d;

    // Every line sees the same number of flops so data stays aligned to the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain  <= '0;
            edge_d <= 1'b0;
        end else begin
            chain[0] <= {pass_in, edge_in};
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            edge_d <= chain[STAGES-1][0];
        end
    end

    assign pass_out = chain[STAGES-1][W:1];
    assign rise     = chain[STAGES-1][0] & ~edge_d;

endmodule

// File: rtl/i2s_video_rx.sv
// Serial pixel link receiver: oversamples bclk/ws/data, aligns words on ws
// transitions, hands RGB888 pixels to a valid/ready consumer, reports frames.
module i2s_video_rx
    import i2s_video_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PIX_BITS     = DEF_PIX_BITS,
    parameter int IDLE_TIMEOUT = 64,
    parameter int CNT_W        = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i2s_bclk,
    input  logic             i2s_ws,
    input  logic             i2s_data,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_pixels,
    output logic             overflow,
    output logic [CNT_W-1:0] dropped_bits
);

    localparam int BCW = $clog2(PIX_BITS + 1);
    localparam int IDW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic ws_s, data_s, rise;

    sync_edge_det #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
        .clk      (clk),
        .rst_n    (reset_n),
        .edge_in  (i2s_bclk),
        .pass_in  ({i2s_data, i2s_ws}),
        .pass_out ({data_s, ws_s}),
        .rise     (rise)
    );

    rx_state_t           state, state_n;
    logic [PIX_BITS-1:0] shreg, shreg_n, word;
    logic [BCW-1:0]      bit_cnt, bit_cnt_n;
    logic                ws_last, ws_last_n;
    logic [IDW-1:0]      idle_cnt, idle_cnt_n;
    logic [CNT_W-1:0]    frame_cnt, frame_cnt_n, frame_pixels_n, dropped_n, drop_inc;
    logic [CNT_W:0]      drop_sum;
    logic [23:0]         pixel_data_n;
    logic                pixel_valid_n, frame_done_n, overflow_n;
    logic                ws_edge, accept, word_done, timeout;

    always_comb begin
        state_n        = state;
        shreg_n        = shreg;
        bit_cnt_n      = bit_cnt;
        ws_last_n      = ws_last;
        idle_cnt_n     = idle_cnt;
        frame_cnt_n    = frame_cnt;
        frame_pixels_n = frame_pixels;
        pixel_data_n   = pixel_data;
        pixel_valid_n  = pixel_valid;
        overflow_n     = overflow;
        frame_done_n   = 1'b0;
        drop_inc       = '0;
        word_done      = 1'b0;

        ws_edge = rise && (ws_s != ws_last);
        accept  = pixel_valid && pixel_ready;
        timeout = !rise && (idle_cnt == IDW'(IDLE_TIMEOUT - 1));
        word    = {shreg[PIX_BITS-2:0], data_s};

        if (rise) begin
            ws_last_n  = ws_s;
            idle_cnt_n = '0;
        end else if (idle_cnt != IDW'(IDLE_TIMEOUT)) begin
            idle_cnt_n = idle_cnt + 1'b1;
        end

        // The shift register holds only the bits received so far, LSB-aligned.
        case (state)
            ALIGN: begin
                if (ws_edge) begin
                    shreg_n   = PIX_BITS'(data_s);
                    bit_cnt_n = BCW'(1);
                    state_n   = RECEIVE;
                end else if (rise) begin
                    drop_inc = CNT_W'(1);
                end
            end
            RECEIVE: begin
                if (ws_edge && bit_cnt != '0) begin
                    drop_inc  = CNT_W'(bit_cnt);
                    shreg_n   = PIX_BITS'(data_s);
                    bit_cnt_n = BCW'(1);
                end else if (rise) begin
                    shreg_n = word;
                    if (bit_cnt == BCW'(PIX_BITS - 1)) begin
                        word_done = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = ALIGN;
        endcase

        drop_sum  = {1'b0, dropped_bits} + {1'b0, drop_inc};
        dropped_n = drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];

        if (accept) begin
            pixel_valid_n = 1'b0;
        end
        if (word_done) begin
            if (!pixel_valid || accept) begin
                pixel_data_n  = expand444(rgb444_t'(word));
                pixel_valid_n = 1'b1;
                if (frame_cnt != CNT_MAX) begin
                    frame_cnt_n = frame_cnt + 1'b1;
                end
            end else begin
                overflow_n = 1'b1;
            end
        end

        // A silent bit clock marks vertical sync; the holder is deliberately kept.
        if (timeout) begin
            state_n = ALIGN;
            if (frame_cnt != '0) begin
                frame_done_n   = 1'b1;
                frame_pixels_n = frame_cnt;
                frame_cnt_n    = '0;
                dropped_n      = '0;
                bit_cnt_n      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ALIGN;
            shreg        <= '0;
            bit_cnt      <= '0;
            ws_last      <= 1'b0;
            idle_cnt     <= '0;
            frame_cnt    <= '0;
            frame_pixels <= '0;
            dropped_bits <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            overflow     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            shreg        <= shreg_n;
            bit_cnt      <= bit_cnt_n;
            ws_last      <= ws_last_n;
            idle_cnt     <= idle_cnt_n;
            frame_cnt    <= frame_cnt_n;
            frame_pixels <= frame_pixels_n;
            dropped_bits <= dropped_n;
            pixel_data   <= pixel_data_n;
            pixel_valid  <= pixel_valid_n;
            overflow     <= overflow_n;
            frame_done   <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_i2s_video_rx.sv
// Self-checking bench for i2s_video_rx: fixed pixel vectors, hand-built
// corner sequences and a randomized frame against a bit-level reference model.
module tb_i2s_video_rx;

    localparam int CNT_W   = 17;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i2s_bclk = 1'b0;
    logic             i2s_ws = 1'b0;
    logic             i2s_data = 1'b0;
    logic             pixel_ready = 1'b0;
    logic [23:0]      pixel_data;
    logic             pixel_valid;
    logic             frame_done;
    logic [CNT_W-1:0] frame_pixels;
    logic             overflow;
    logic [CNT_W-1:0] dropped_bits;

    i2s_video_rx #(
        .SYNC_STAGES  (2),
        .PIX_BITS     (12),
        .IDLE_TIMEOUT (64),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i2s_bclk     (i2s_bclk),
        .i2s_ws       (i2s_ws),
        .i2s_data     (i2s_data),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .overflow     (overflow),
        .dropped_bits (dropped_bits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] word;
        logic [23:0] expected;
    } vec_t;

    vec_t        vecs[5];
    int          n_checks = 0;
    int          n_pass = 0;
    int          fd_count = 0;
    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];
    bit          rand_ready = 1'b0;
    bit          cur_ws = 1'b0;

    // Reference model state: a word-level view of the link.
    bit m_aligned;
    bit m_ws_last;
    int m_acc;
    int m_cnt;
    int m_dropped;
    int m_frame_cnt;
    int m_frame_pixels;

    // Consumer side: record every accepted pixel and every frame_done cycle.
    always @(negedge clk) begin
        if (reset_n && pixel_valid && pixel_ready) got_q.push_back(pixel_data);
        if (reset_n && frame_done) fd_count++;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic logic [23:0] ref_expand(input int w);
        int r, g, b;
        r = (w >> 8) & 15;
        g = (w >> 4) & 15;
        b = w & 15;
        return 24'((r * 17) * 65536 + (g * 17) * 256 + b * 17);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    endtask

    task automatic model_reset();
        m_aligned = 0; m_ws_last = 0; m_acc = 0; m_cnt = 0;
        m_dropped = 0; m_frame_cnt = 0; m_frame_pixels = 0;
        exp_q.delete();
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_bit(input bit ws, input bit d);
        bit edge_seen;
        edge_seen = (ws != m_ws_last);
        m_ws_last = ws;
        if (!m_aligned) begin
            if (edge_seen) begin
                m_aligned = 1; m_acc = d; m_cnt = 1;
            end else begin
                m_dropped = sat(m_dropped + 1);
            end
        end else if (edge_seen && m_cnt != 0) begin
            m_dropped = sat(m_dropped + m_cnt);
            m_acc = d; m_cnt = 1;
        end else begin
            m_acc = m_acc * 2 + d;
            m_cnt++;
            if (m_cnt == 12) begin
                exp_q.push_back(ref_expand(m_acc));
                m_frame_cnt = sat(m_frame_cnt + 1);
                m_acc = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic apply_bit(input bit ws, input bit d);
        i2s_ws   = ws;
        i2s_data = d;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rand_ready) pixel_ready = ($urandom_range(0, 3) != 0);
            if (c == 3) i2s_bclk = 1'b1;
            if (c == 7) i2s_bclk = 1'b0;
        end
        model_bit(ws, d);
    endtask

    task automatic apply_word(input bit toggle, input logic [11:0] w);
        if (toggle) cur_ws = ~cur_ws;
        for (int i = 11; i >= 0; i--) apply_bit(cur_ws, w[i]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; i2s_bclk = 1'b0; i2s_ws = 1'b0; i2s_data = 1'b0;
        cur_ws = 1'b0; pixel_ready = 1'b0; rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        got_q.delete();
    endtask

    task automatic wait_pixels(input int n, input string name);
        for (int i = 0; i < 200 && got_q.size() < n; i++) @(negedge clk);
        check_output($sformatf("%s_count", name), got_q.size(), n);
    endtask

    task automatic take_pixel(output logic [23:0] v);
        if (got_q.size() > 0) v = got_q.pop_front();
        else v = 'x;
    endtask

    task automatic do_idle(input string name);
        int base;
        bit pulse_exp;
        base = fd_count;
        i2s_bclk = 1'b0;
        repeat (90) @(posedge clk);
        @(negedge clk);
        pulse_exp = (m_frame_cnt > 0);
        if (pulse_exp) begin
            m_frame_pixels = m_frame_cnt;
            m_frame_cnt = 0; m_dropped = 0; m_cnt = 0;
        end
        m_aligned = 0;
        check_output($sformatf("%s_pulses", name), fd_count - base, pulse_exp ? 1 : 0);
        if (pulse_exp) check_output($sformatf("%s_frame_pixels", name), frame_pixels, m_frame_pixels);
    endtask

    initial begin
        logic [23:0] v;
        int          k;
        bit          tog;

        vecs[0] = '{12'hA5C, 24'hAA55CC};
        vecs[1] = '{12'h123, 24'h112233};
        vecs[2] = '{12'hFFF, 24'hFFFFFF};
        vecs[3] = '{12'h001, 24'h000011};
        vecs[4] = '{12'h7E3, 24'h77EE33};

        // Reset values, and a timeout with an empty frame gives no pulse.
        do_reset();
        check_output("rst_valid_done_ovf", {pixel_valid, frame_done, overflow}, 3'b000);
        check_output("rst_pixel_data", pixel_data, 24'h0);
        check_output("rst_frame_pixels", frame_pixels, 0);
        check_output("rst_dropped", dropped_bits, 0);
        do_idle("empty_idle");

        // Aligned words from the vector table.
        do_reset();
        pixel_ready = 1'b1;
        foreach (vecs[i]) begin
            apply_word(1'b1, vecs[i].word);
            wait_pixels(1, $sformatf("vec%0d", i));
            take_pixel(v);
            check_output($sformatf("vec%0d_pixel", i), v, vecs[i].expected);
        end
        check_output("vec_dropped", dropped_bits, 0);

        // Junk before the first ws edge is counted, then the word is clean.
        do_reset();
        pixel_ready = 1'b1;
        for (int i = 0; i < 7; i++) apply_bit(1'b0, 1'($urandom));
        apply_word(1'b1, 12'h123);
        wait_pixels(1, "junk");
        take_pixel(v);
        check_output("junk_pixel", v, 24'h112233);
        check_output("junk_dropped", dropped_bits, 7);

        // Misaligned ws: edge after 4 bits of a word.
        do_reset();
        pixel_ready = 1'b1;
        apply_word(1'b1, 12'h5A5);
        cur_ws = 1'b0;
        for (int i = 0; i < 4; i++) apply_bit(cur_ws, 1'($urandom));
        apply_word(1'b1, 12'h3C9);
        wait_pixels(2, "misalign");
        take_pixel(v);
        check_output("misalign_pixel0", v, 24'h55AA55);
        take_pixel(v);
        check_output("misalign_pixel1", v, 24'h33CC99);
        check_output("misalign_dropped", dropped_bits, 4);

        // Reset in the middle of a word while a pixel is pending.
        do_reset();
        apply_word(1'b1, 12'hA5C);
        repeat (3) @(negedge clk);
        check_output("hold_valid", pixel_valid, 1'b1);
        check_output("hold_pixel", pixel_data, 24'hAA55CC);
        for (int i = 0; i < 5; i++) apply_bit(1'b0, 1'($urandom));
        reset_n = 1'b0;
        #1;
        check_output("midrst_valid_done_ovf", {pixel_valid, frame_done, overflow}, 3'b000);
        check_output("midrst_pixel_data", pixel_data, 24'h0);
        check_output("midrst_dropped", dropped_bits, 0);
        i2s_ws = 1'b0; cur_ws = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        got_q.delete();
        pixel_ready = 1'b1;
        apply_word(1'b0, 12'hABC);
        repeat (20) @(negedge clk);
        check_output("midrst_no_pixel", got_q.size(), 0);
        check_output("midrst_dropped12", dropped_bits, m_dropped);
        apply_word(1'b1, 12'h0F0);
        wait_pixels(1, "midrst");
        take_pixel(v);
        check_output("midrst_pixel", v, 24'h00FF00);

        // Backpressure: second word dropped, first held stable.
        do_reset();
        apply_word(1'b1, 12'hFFF);
        apply_word(1'b1, 12'h001);
        repeat (4) @(negedge clk);
        check_output("bp_valid", pixel_valid, 1'b1);
        check_output("bp_pixel", pixel_data, 24'hFFFFFF);
        check_output("bp_overflow", overflow, 1'b1);
        @(posedge clk); #1 pixel_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("bp_valid_drop", pixel_valid, 1'b0);
        take_pixel(v);
        check_output("bp_accepted", v, 24'hFFFFFF);
        check_output("bp_overflow_sticky", overflow, 1'b1);

        // Randomized 100-pixel frame with occasional misalignment.
        do_reset();
        rand_ready = 1'b1;
        while (m_frame_cnt < 100) begin
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, 11);
                cur_ws = ~cur_ws;
                for (int i = 0; i < k; i++) apply_bit(cur_ws, 1'($urandom));
                tog = 1'b1;
            end else begin
                tog = !m_aligned || ($urandom_range(0, 3) != 0);
            end
            apply_word(tog, 12'($urandom));
        end
        rand_ready = 1'b0;
        pixel_ready = 1'b1;
        check_output("frame_dropped", dropped_bits, m_dropped);
        check_output("frame_overflow", overflow, 1'b0);
        do_idle("frame1");
        check_output("frame1_is_100", frame_pixels, 100);
        check_output("frame1_stream_len", got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            take_pixel(v);
            check_output($sformatf("frame1_pix%0d", 100 - exp_q.size()), v, exp_q.pop_front());
        end
        check_output("frame1_dropped_clr", dropped_bits, 0);

        // The next frame counts from zero again.
        for (int i = 0; i < 3; i++) apply_word(1'b1, 12'($urandom));
        do_idle("frame2");
        check_output("frame2_is_3", frame_pixels, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
